// File: rtl/time_set_ctrl.sv
// Purpose : sequences the h/m/s counter chain; RUN passes the 1 Hz tick, two buttons step
//           through hour/minute set modes with press-and-hold auto-repeat and a blink mask.
// Latency : sec_en is tick_1hz delayed 1 clk; inc strobes 1 clk after the debounced press event.
// Backpr. : none; every output is a fire-and-forget one-clk strobe or a level.
//
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   tick_1hz  one-clk strobe per second from the prescaler
//   btn_mode  raw mode button (async, active-high)
//   btn_inc   raw increment button (async, active-high)
//   sec_en    one-clk enable to the seconds stage (RUN only)
//   sec_clr   one-clk clear to the seconds stage, issued when set mode is left
//   min_inc   one-clk increment strobe to the minutes stage
//   hr_inc    one-clk increment strobe to the hours stage
//   mode      00 RUN, 01 SET_HR, 10 SET_MIN
//   blink     1 = blank the field selected by mode
module time_set_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_RATE     = 10_000_000,
  parameter int unsigned BLINK_HALF      = 25_000_000,
  parameter int unsigned TIMEOUT_TICKS   = 30
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       sec_en,
  output logic       sec_clr,
  output logic       min_inc,
  output logic       hr_inc,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);
  localparam int unsigned BLK_W   = $clog2(BLINK_HALF + 1);
  localparam int unsigned TMO_W   = $clog2(TIMEOUT_TICKS + 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_SET_HR  = 2'b01,
    ST_SET_MIN = 2'b10
  } state_t;

  state_t state, state_nxt;

  // ------------------------------------------------------------------
  // Button conditioning: bit 0 = mode, bit 1 = inc
  // ------------------------------------------------------------------
  logic [1:0]            btn_raw;
  logic [1:0]            sync_a, sync_b;
  logic [1:0]            deb, deb_q;
  logic [1:0][DEB_W-1:0] deb_cnt;
  logic                  mode_ev, inc_ev;

  assign btn_raw = {btn_inc, btn_mode};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_a  <= '0;
      sync_b  <= '0;
      deb     <= '0;
      deb_q   <= '0;
      deb_cnt <= '0;
    end else begin
      sync_a <= btn_raw;
      sync_b <= sync_a;
      deb_q  <= deb;
      for (int i = 0; i < 2; i++) begin
        // deb_cnt counts consecutive clks the synced level disagrees with deb;
        // any agreeing clk starts the count over, so short glitches never land.
        if (sync_b[i] != deb[i]) begin
          if (deb_cnt[i] == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
            deb[i]     <= sync_b[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  assign mode_ev = deb[0] & ~deb_q[0];
  assign inc_ev  = deb[1] & ~deb_q[1];

  // ------------------------------------------------------------------
  // Auto-repeat / timeout / blink bookkeeping
  // ------------------------------------------------------------------
  logic             rpt_act, rpt_first;
  logic [RPT_W-1:0] rpt_cnt, rpt_tgt;
  logic             rpt_due;
  logic [TMO_W-1:0] tmo_cnt;
  logic             timeout_hit;
  logic [BLK_W-1:0] blk_cnt;
  logic             in_set;

  assign in_set  = (state != ST_RUN);
  assign rpt_tgt = rpt_first ? RPT_W'(REPEAT_DELAY - 1) : RPT_W'(REPEAT_RATE - 1);
  // rpt_cnt holds clks elapsed since the last strobe, so the strobe lands
  // exactly REPEAT_DELAY / REPEAT_RATE clks after its predecessor's reference.
  assign rpt_due = rpt_act & deb[1] & (rpt_cnt >= rpt_tgt);
  // A press landing on the final tick restarts the window instead of exiting.
  assign timeout_hit = in_set & tick_1hz & ~inc_ev & (tmo_cnt == TMO_W'(TIMEOUT_TICKS - 1));

  // ------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------
  logic sec_en_nxt, sec_clr_nxt, min_inc_nxt, hr_inc_nxt, inc_fire;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    sec_en_nxt  = 1'b0;
    sec_clr_nxt = 1'b0;
    min_inc_nxt = 1'b0;
    hr_inc_nxt  = 1'b0;
    // Mode press always takes priority; an inc event in the same clk is dropped.
    case (state)
      ST_RUN: begin
        sec_en_nxt = tick_1hz;
        if (mode_ev) begin
          state_nxt = ST_SET_HR;
        end
      end
      ST_SET_HR: begin
        if (mode_ev) begin
          state_nxt = ST_SET_MIN;
        end else if (timeout_hit) begin
          state_nxt   = ST_RUN;
          sec_clr_nxt = 1'b1;
        end else if (inc_ev || rpt_due) begin
          hr_inc_nxt = 1'b1;
        end
      end
      ST_SET_MIN: begin
        if (mode_ev || timeout_hit) begin
          state_nxt   = ST_RUN;
          sec_clr_nxt = 1'b1;
        end else if (inc_ev || rpt_due) begin
          min_inc_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  assign inc_fire = hr_inc_nxt | min_inc_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sec_en  <= 1'b0;
      sec_clr <= 1'b0;
      min_inc <= 1'b0;
      hr_inc  <= 1'b0;
    end else begin
      sec_en  <= sec_en_nxt;
      sec_clr <= sec_clr_nxt;
      min_inc <= min_inc_nxt;
      hr_inc  <= hr_inc_nxt;
    end
  end

  assign mode = state;

  // Repeat engine. Any state change disarms it, so an inc held across a mode
  // change stays silent until its debounced level drops and a fresh press arrives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rpt_act   <= 1'b0;
      rpt_first <= 1'b0;
      rpt_cnt   <= '0;
    end else if ((state_nxt != state) || (state == ST_RUN)) begin
      rpt_act   <= 1'b0;
      rpt_first <= 1'b0;
      rpt_cnt   <= '0;
    end else if (inc_ev) begin
      // The event clk itself is clk 0, so the count is 1 in the pulse clk.
      rpt_act   <= 1'b1;
      rpt_first <= 1'b1;
      rpt_cnt   <= RPT_W'(1);
    end else if (!deb[1]) begin
      rpt_act   <= 1'b0;
      rpt_first <= 1'b0;
      rpt_cnt   <= '0;
    end else if (rpt_due) begin
      rpt_first <= 1'b0;
      rpt_cnt   <= '0;
    end else if (rpt_act) begin
      rpt_cnt <= rpt_cnt + 1'b1;
    end
  end

  // Set-mode inactivity timeout, counted in seconds ticks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
    end else if ((state_nxt == ST_RUN) || (state_nxt != state) || mode_ev || inc_ev) begin
      tmo_cnt <= '0;
    end else if (tick_1hz) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Blink: starts visible on entry and after every increment strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink   <= 1'b0;
      blk_cnt <= '0;
    end else if ((state_nxt == ST_RUN) || (state_nxt != state) || inc_fire) begin
      blink   <= 1'b0;
      blk_cnt <= '0;
    end else if (blk_cnt == BLK_W'(BLINK_HALF - 1)) begin
      blink   <= ~blink;
      blk_cnt <= '0;
    end else begin
      blk_cnt <= blk_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with shortened timing parameters.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// A button raised just after edge 0 gives its debounced press event in the
// interval after edge 6, so any strobe it causes is visible after edge 7.
module tb_time_set_ctrl;

  localparam int unsigned DEB  = 4;
  localparam int unsigned RDLY = 20;
  localparam int unsigned RRAT = 5;
  localparam int unsigned BLK  = 8;
  localparam int unsigned TMO  = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       sec_en, sec_clr, min_inc, hr_inc, blink;
  logic [1:0] mode;

  int n_assert = 0;
  int n_fail   = 0;
  int last_p;
  int n_pulse;
  logic exp_p;

  time_set_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RDLY),
    .REPEAT_RATE     (RRAT),
    .BLINK_HALF      (BLK),
    .TIMEOUT_TICKS   (TMO)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .tick_1hz (tick_1hz),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .sec_en   (sec_en),
    .sec_clr  (sec_clr),
    .min_inc  (min_inc),
    .hr_inc   (hr_inc),
    .mode     (mode),
    .blink    (blink)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n clks; every sampled clk also checks the strobes are mutually exclusive.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("at_most_one_strobe", 32'($countones({sec_en, sec_clr, min_inc, hr_inc}) <= 1), 1);
    end
  endtask

  // Full mode press (held 10 clks) from state cur, expecting state nxt.
  task automatic press_mode(input logic [1:0] cur, input logic [1:0] nxt);
    btn_mode = 1'b1;
    step(6);
    chk("mode_before_event", mode, cur);
    chk("sec_clr_before_event", sec_clr, 0);
    step(1);
    chk("mode_after_event", mode, nxt);
    chk("sec_clr_on_transition", sec_clr, (cur == 2'b10) && (nxt == 2'b00));
    chk("blink_on_entry", blink, 0);
    step(3);
    btn_mode = 1'b0;
    step(4);
    chk("sec_clr_single", sec_clr, 0);
    chk("blink_before_half", blink, 0);
    step(1);
    chk("blink_after_half", blink, nxt != 2'b00);
    step(3);
  endtask

  // Short inc press (held 10 clks, below the repeat delay).
  task automatic press_inc(input logic exp_hr, input logic exp_min);
    btn_inc = 1'b1;
    step(6);
    chk("inc_quiet_at_event", hr_inc | min_inc, 0);
    step(1);
    chk("hr_inc_after_press", hr_inc, exp_hr);
    chk("min_inc_after_press", min_inc, exp_min);
    step(1);
    chk("inc_strobe_one_clk", hr_inc | min_inc, 0);
    step(2);
    btn_inc = 1'b0;
    step(8);
  endtask

  // One tick_1hz strobe followed by 9 idle clks.
  task automatic tick_once(input logic [1:0] exp_mode, input logic exp_clr);
    chk("sec_en_idle_before_tick", sec_en, 0);
    tick_1hz = 1'b1;
    step(1);
    tick_1hz = 1'b0;
    chk("mode_after_tick", mode, exp_mode);
    chk("sec_clr_after_tick", sec_clr, exp_clr);
    chk("sec_en_in_set_mode", sec_en, 0);
    step(1);
    chk("sec_clr_after_tick_done", sec_clr, 0);
    step(8);
  endtask

  initial begin
    // Reset state
    step(2);
    chk("reset_outputs", {sec_en, sec_clr, min_inc, hr_inc, mode, blink}, 0);
    reset_n = 1'b1;
    step(2);
    chk("post_reset_mode", mode, 0);

    // 1: RUN passes ticks with one clk latency; inc ignored
    for (int k = 0; k < 3; k++) begin
      chk("sec_en_before_tick", sec_en, 0);
      tick_1hz = 1'b1;
      step(1);
      tick_1hz = 1'b0;
      chk("sec_en_follows_tick", sec_en, 1);
      step(1);
      chk("sec_en_one_clk", sec_en, 0);
      step(8);
    end
    press_inc(1'b0, 1'b0);
    chk("run_mode_kept", mode, 0);

    // 2: short glitch rejected, then full mode cycle
    btn_mode = 1'b1;
    step(3);
    btn_mode = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      chk("glitch_no_mode_change", mode, 0);
    end
    press_mode(2'b00, 2'b01);
    press_mode(2'b01, 2'b10);
    press_mode(2'b10, 2'b00);

    // 3: hold inc in SET_HR. btn high for 44 clks keeps the debounced level
    // high from the event through event+43: strobes at +1, +20, +25 .. +40.
    press_mode(2'b00, 2'b01);
    btn_inc = 1'b1;
    step(6);
    chk("hr_inc_quiet_at_event", hr_inc, 0);
    last_p  = 0;
    n_pulse = 0;
    for (int j = 1; j <= 60; j++) begin
      step(1);
      exp_p = (j == 1) || (j >= 20 && j <= 40 && (j % 5) == 0);
      if (exp_p) last_p = j;
      n_pulse += int'(hr_inc);
      chk($sformatf("hr_inc_repeat_t%0d", j), hr_inc, exp_p);
      chk($sformatf("min_inc_silent_t%0d", j), min_inc, 0);
      chk($sformatf("blink_t%0d", j), blink, ((j - last_p) / 8) % 2);
      if (j == 38) btn_inc = 1'b0;
    end
    chk("hr_inc_pulse_count", n_pulse, 6);
    chk("still_set_hr", mode, 1);

    // 5: mode and inc events in the same clk; inc held afterwards
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    step(6);
    chk("both_before_event", mode, 1);
    step(1);
    chk("mode_wins", mode, 2);
    chk("hr_inc_discarded", hr_inc, 0);
    chk("min_inc_discarded", min_inc, 0);
    step(3);
    btn_mode = 1'b0;
    for (int k = 0; k < 25; k++) begin
      step(1);
      chk($sformatf("held_inc_silent_%0d", k), hr_inc | min_inc, 0);
    end
    btn_inc = 1'b0;
    step(10);
    press_inc(1'b0, 1'b1);

    // 4: timeout; an inc press after tick 2 restarts the count
    tick_once(2'b10, 1'b0);
    tick_once(2'b10, 1'b0);
    press_inc(1'b0, 1'b1);
    tick_once(2'b10, 1'b0);
    tick_once(2'b10, 1'b0);
    tick_once(2'b00, 1'b1);
    press_mode(2'b00, 2'b01);
    press_mode(2'b01, 2'b10);
    tick_once(2'b10, 1'b0);
    tick_once(2'b10, 1'b0);
    tick_once(2'b00, 1'b1);

    // 6: async reset during a repeat strobe in SET_MIN
    press_mode(2'b00, 2'b01);
    press_mode(2'b01, 2'b10);
    btn_inc = 1'b1;
    step(6);
    step(1);
    chk("min_inc_first", min_inc, 1);
    step(19);
    chk("min_inc_first_repeat", min_inc, 1);
    btn_mode = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", {sec_en, sec_clr, min_inc, hr_inc, mode, blink}, 0);
    step(3);
    chk("reset_held_outputs", {sec_en, sec_clr, min_inc, hr_inc, mode, blink}, 0);
    reset_n = 1'b1;
    step(6);
    chk("held_needs_debounce", mode, 0);
    step(1);
    chk("held_mode_after_debounce", mode, 1);
    chk("held_inc_discarded", hr_inc, 0);
    for (int k = 0; k < 10; k++) begin
      step(1);
      chk($sformatf("post_reset_inc_silent_%0d", k), hr_inc | min_inc, 0);
    end
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    step(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
